// File: rtl/not_equal_array_if.sv
// Bus bundle for not_equal_array: enable, per-channel a/b events and the
// registered results handed to downstream WTA/STDP logic.
interface not_equal_array_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned TW     = 4
);
    logic                   en;
    logic [NUM_CH-1:0]      a;
    logic [NUM_CH-1:0]      b;
    logic [NUM_CH-1:0]      y;
    logic [NUM_CH*TW-1:0]   y_time;
    logic [TW-1:0]          gamma_cnt;
    logic                   gamma_done;
    logic [NUM_CH-1:0]      fired_mask;

    modport master (
        output en, a, b,
        input  y, y_time, gamma_cnt, gamma_done, fired_mask
    );

    modport slave (
        input  en, a, b,
        output y, y_time, gamma_cnt, gamma_done, fired_mask
    );
endinterface

// File: rtl/not_equal_array.sv
// Multi-channel temporal not-equal operator: a passes to y unless a and b
// arrive on the same gamma sample; all channels re-arm at each gamma wrap.
module not_equal_array #(
    parameter int unsigned NUM_CH             = 8,
    parameter int unsigned GAMMA_CYCLE_LENGTH = 16,
    parameter int unsigned PULSE_WIDTH        = 8,
    parameter int unsigned MODE               = 0
) (
    input logic              aclk,
    input logic              grst,
    not_equal_array_if.slave bus
);
    localparam int unsigned TW = $clog2(GAMMA_CYCLE_LENGTH);
    localparam int unsigned PW = $clog2(PULSE_WIDTH + 1);

    localparam logic [1:0] ST_ARMED    = 2'd0;
    localparam logic [1:0] ST_DIVERGED = 2'd1;
    localparam logic [1:0] ST_PASS     = 2'd2;
    localparam logic [1:0] ST_BLOCK    = 2'd3;

    localparam logic [TW-1:0] CNT_LAST = TW'(GAMMA_CYCLE_LENGTH - 1);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PULSE_WIDTH);

    logic [NUM_CH-1:0][1:0]    state_q, state_d;
    logic [NUM_CH-1:0][PW-1:0] pcnt_q, pcnt_d;
    logic [NUM_CH-1:0]         y_q, y_d;
    logic [NUM_CH*TW-1:0]      y_time_q, y_time_d;
    logic [TW-1:0]             cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic [NUM_CH-1:0]         mask_q, mask_d;
    logic                      wrap_c;

    // Next-state: gamma counter, per-channel FSM, output shaping
    always_comb begin
        wrap_c   = bus.en && (cnt_q == CNT_LAST);
        cnt_d    = cnt_q;
        done_d   = wrap_c;
        mask_d   = '0;
        y_d      = y_q;
        y_time_d = y_time_q;
        state_d  = state_q;
        pcnt_d   = pcnt_q;

        if (wrap_c) begin
            // Wrap-edge samples are dropped; only PASS channels count as fired
            cnt_d    = '0;
            y_d      = '0;
            y_time_d = '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                mask_d[i]  = (state_q[i] == ST_PASS);
                state_d[i] = ST_ARMED;
                pcnt_d[i]  = '0;
            end
        end else if (bus.en) begin
            cnt_d = cnt_q + TW'(1);
            for (int i = 0; i < int'(NUM_CH); i++) begin
                case (state_q[i])
                    ST_ARMED: begin
                        if (bus.a[i] && bus.b[i]) begin
                            state_d[i] = ST_BLOCK;
                        end else if (bus.a[i]) begin
                            state_d[i]              = ST_PASS;
                            y_d[i]                  = 1'b1;
                            y_time_d[i*TW +: TW]    = cnt_q;
                            pcnt_d[i]               = PW'(1);
                        end else if (bus.b[i]) begin
                            state_d[i] = ST_DIVERGED;
                        end
                    end
                    ST_DIVERGED: begin
                        if (bus.a[i]) begin
                            state_d[i]              = ST_PASS;
                            y_d[i]                  = 1'b1;
                            y_time_d[i*TW +: TW]    = cnt_q;
                            pcnt_d[i]               = PW'(1);
                        end
                    end
                    ST_PASS: begin
                        // Pulse mode: count high cycles, drop y once the width is reached
                        if ((MODE != 0) && y_q[i]) begin
                            if (pcnt_q[i] == PCNT_MAX) begin
                                y_d[i] = 1'b0;
                            end else begin
                                pcnt_d[i] = pcnt_q[i] + PW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state_q  <= '0;
            pcnt_q   <= '0;
            y_q      <= '0;
            y_time_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            y_q      <= y_d;
            y_time_q <= y_time_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            mask_q   <= mask_d;
        end
    end

    assign bus.y          = y_q;
    assign bus.y_time     = y_time_q;
    assign bus.gamma_cnt  = cnt_q;
    assign bus.gamma_done = done_q;
    assign bus.fired_mask = mask_q;
endmodule
